// File: rtl/p18_debounce_scanner.sv
// p18_debounce_scanner: 2-flop synchronizers plus a round-robin, time-multiplexed debouncer
// for WIDTH board inputs, with per-channel rise/fall pulses.
// Optional sticky interrupt (irq/irq_clr ports) is built when P18_DEBOUNCE_IRQ_EN is defined.
module p18_debounce_scanner #(
    parameter int   WIDTH         = 4,
    parameter logic DEFAULT_VALUE = 1'b0,
    parameter int   TICK_DIV      = 1024,
    parameter int   STABLE_COUNT  = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
`ifdef P18_DEBOUNCE_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_clr
`endif
);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_COUNT);
    localparam logic [WIDTH-1:0] RST_LEVEL = {WIDTH{DEFAULT_VALUE}};

    typedef enum logic {IDLE, SCAN} fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] s_meta;
    logic [WIDTH-1:0] s;
    logic [PW-1:0]    presc;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt [WIDTH];
    logic             tick;

    // A scan must finish before the next tick, and the counter needs at least one bit.
    generate
        if (WIDTH < 1 || WIDTH > 16 || TICK_DIV < WIDTH + 1 || STABLE_COUNT < 2 || STABLE_COUNT > 15) begin : g_bad_params
            $error("p18_debounce_scanner: illegal parameter values");
        end
    endgenerate

    assign tick = presc == PW'(TICK_DIV - 1);

    // Two-flop synchronizer on every raw input
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            s_meta <= RST_LEVEL;
            s      <= RST_LEVEL;
        end else begin
            s_meta <= in;
            s      <= s_meta;
        end
    end

    // Free-running scan prescaler, independent of the FSM
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            presc <= '0;
        else
            presc <= tick ? '0 : presc + 1'b1;
    end

    // Scan FSM: one channel per cycle, changes accepted after STABLE_COUNT differing samples
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fsm   <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            state <= RST_LEVEL;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (fsm == IDLE) begin
                if (tick) begin
                    fsm  <= SCAN;
                    idx  <= '0;
                    busy <= 1'b1;
                end
            end else begin
                if (s[idx] == state[idx])
                    cnt[idx] <= '0;
                else if (cnt[idx] == CW'(STABLE_COUNT - 1)) begin
                    cnt[idx]   <= '0;
                    state[idx] <= s[idx];
                    rise[idx]  <= s[idx];
                    fall[idx]  <= ~s[idx];
                end else
                    cnt[idx] <= cnt[idx] + 1'b1;
                if (idx == IW'(WIDTH - 1)) begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end else
                    idx <= idx + 1'b1;
            end
        end
    end

`ifdef P18_DEBOUNCE_IRQ_EN
    // Sticky interrupt: a new edge outranks a simultaneous clear
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            irq <= 1'b0;
        else
            irq <= (|rise) | (|fall) | (irq & ~irq_clr);
    end
`endif

endmodule

// File: tb/tb_p18_debounce_scanner.sv
// tb_p18_debounce_scanner: randomized scoreboard bench for p18_debounce_scanner
// (WIDTH=4, TICK_DIV=8, STABLE_COUNT=3); define P18_DEBOUNCE_IRQ_EN to cover irq.
module tb_p18_debounce_scanner;
    localparam int W  = 4;
    localparam int TD = 8;
    localparam int SC = 3;

    typedef struct packed {
        logic [W-1:0] st;
        logic [W-1:0] ri;
        logic [W-1:0] fa;
        logic         bz;
        logic         iq;
    } obs_t;

    logic         clk = 1'b0;
    logic         nRst = 1'b1;
    logic         irq_clr = 1'b0;
    logic [W-1:0] in_r = 4'hF;
    logic [W-1:0] state, rise, fall;
    logic         busy, irq;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int busy_cycles = 0;

    obs_t     exp_q[$];
    obs_t     e, g;
    bit [W-1:0] hist[$];
    bit [W-1:0] m_state, m_rise, m_fall, smp;
    int       m_cnt[W];
    bit       m_busy, m_irq;
    int       n, k;

    p18_debounce_scanner #(
        .WIDTH(W), .DEFAULT_VALUE(1'b0), .TICK_DIV(TD), .STABLE_COUNT(SC)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .in(in_r),
        .state(state),
        .rise(rise),
        .fall(fall),
        .busy(busy)
`ifdef P18_DEBOUNCE_IRQ_EN
        ,
        .irq(irq),
        .irq_clr(irq_clr)
`endif
    );

`ifndef P18_DEBOUNCE_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: edge n after reset release; channel k is sampled on edges
    // n >= TD with n mod TD == k, seeing the input captured two edges earlier.
    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            n = 0;
            hist.delete();
            exp_q.delete();
            m_state = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_busy  = 1'b0;
            m_irq   = 1'b0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
`ifdef P18_DEBOUNCE_IRQ_EN
            m_irq = (m_rise | m_fall) != 0 || (m_irq && !irq_clr);
`endif
            hist.push_back(in_r);
            if (hist.size() > 3) void'(hist.pop_front());
            smp = hist.size() == 3 ? hist[0] : '0;
            m_rise = '0;
            m_fall = '0;
            if (n >= TD && n % TD < W) begin
                k = n % TD;
                if (smp[k] == m_state[k])
                    m_cnt[k] = 0;
                else begin
                    m_cnt[k]++;
                    if (m_cnt[k] == SC) begin
                        m_cnt[k]   = 0;
                        m_state[k] = smp[k];
                        m_rise[k]  = smp[k];
                        m_fall[k]  = !smp[k];
                    end
                end
            end
            m_busy = n + 1 >= TD && (n + 1) % TD < W;
            exp_q.push_back({m_state, m_rise, m_fall, m_busy, m_irq});
            n++;
        end
    end

    // Monitor: compare every presented output cycle against the scoreboard
    always @(negedge clk) begin
        if (nRst) begin
            pulses      += $countones(rise | fall);
            busy_cycles += int'(busy);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {state, rise, fall, busy, irq};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got st=%h ri=%h fa=%h busy=%b irq=%b exp st=%h ri=%h fa=%h busy=%b irq=%b",
                             $time, g.st, g.ri, g.fa, g.bz, g.iq, e.st, e.ri, e.fa, e.bz, e.iq);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int c);
        repeat (c) @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, p0, b0;
        #3 nRst = 1'b0;
        #1;
        chk("reset_state", 32'(state), 0);
        chk("reset_rise", 32'(rise), 0);
        chk("reset_fall", 32'(fall), 0);
        chk("reset_busy", 32'(busy), 0);
        cyc(3);
        nRst = 1'b1;
        cyc(40);
        chk("release_state", 32'(state), 32'hF);
        chk("release_pulses", pulses, 4);

        in_r = 4'hB;
        cyc(40);
        chk("step_setup", 32'(state), 32'hB);
        p0 = pulses;
        in_r = 4'hF;
        t = 0;
        while (state[2] !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t > 2 + SC * TD + W) begin
            errors++;
            $display("FAIL step_latency got=%0d cycles limit=%0d", t, 2 + SC * TD + W);
        end
        cyc(10);
        chk("step_pulses", pulses - p0, 1);

        in_r = 4'h5;
        cyc(40);
        p0 = pulses;
        repeat (10) begin
            in_r[1] = 1'b1;
            cyc(2 * TD);
            in_r[1] = 1'b0;
            cyc(TD);
        end
        cyc(10);
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_state", 32'(state), 32'h5);

        b0 = busy_cycles;
        cyc(10 * TD);
        chk("busy_duty", busy_cycles - b0, 10 * W);

        repeat (150) begin
            if ($urandom_range(0, 5) == 0) in_r = W'($urandom);
            cyc(1);
        end
        repeat (40) begin
            in_r = W'($urandom);
            cyc($urandom_range(1, 60));
        end

        in_r = 4'h7;
        cyc(40);
        in_r = 4'hF;
        t = 0;
        while (!(m_cnt[3] == 2 && m_busy) && t < 100) begin
            cyc(1);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL midscan_wait got=%0d cycles limit=100", t);
        end
        #1 nRst = 1'b0;
        #1;
        chk("midscan_state", 32'(state), 0);
        chk("midscan_pulses", 32'(rise | fall), 0);
        chk("midscan_busy", 32'(busy), 0);
        cyc(2);
        nRst = 1'b1;
        cyc(20);
        chk("midscan_early", 32'(state), 0);
        cyc(20);
        chk("midscan_late", 32'(state), 32'hF);

`ifdef P18_DEBOUNCE_IRQ_EN
        in_r = 4'hE;
        t = 0;
        while (!m_fall[0] && t < 60) begin
            cyc(1);
            t++;
        end
        chk("irq_fall0_seen", 32'(m_fall[0]), 1);
        cyc(2);
        chk("irq_set", 32'(irq), 1);
        in_r = 4'h6;
        t = 0;
        while (!m_fall[3] && t < 60) begin
            cyc(1);
            t++;
        end
        chk("irq_fall3_seen", 32'(m_fall[3]), 1);
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        chk("irq_set_wins", 32'(irq), 1);
        cyc(3);
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        chk("irq_clear", 32'(irq), 0);
`endif

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
